spi_debug_ctrl: RTL

// - SPI mode-3 slave that takes debugger-to-CPU control frames.
// - It is the write path of the debug link. The debugger drives sclk_i, csb_i and si_i.
// - Decoded frames set halt/step/breakpoint controls and register-override writes for the hack CPU.
// - While the command byte shifts in, so_o returns a status byte.
// - All state lives in the sclk_i domain. CPU-side logic synchronises the *_tgl_o toggles.

---
 rtl/spi_debug_pkg.sv | 26 ++
 rtl/spi_frame_rx.sv | 53 +++++
 rtl/spi_debug_ctrl.sv | 72 +++++++
 3 files changed

// File: rtl/spi_debug_pkg.sv
// Shared types and frame geometry for the SPI debug control link.
package spi_debug_pkg;

  localparam int CMD_W     = 8;
  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = CMD_W + DATA_W;

  typedef enum logic [CMD_W-1:0] {
    CMD_HALT   = 8'h01,
    CMD_RUN    = 8'h02,
    CMD_STEP   = 8'h03,
    CMD_WR_D   = 8'h10,
    CMD_WR_A   = 8'h11,
    CMD_WR_PC  = 8'h12,
    CMD_BPADDR = 8'h20,
    CMD_BPEN   = 8'h21,
    CMD_CLRERR = 8'h2F
  } cmd_e;

  typedef enum logic [1:0] {
    SEL_D  = 2'd0,
    SEL_A  = 2'd1,
    SEL_PC = 2'd2
  } wr_sel_e;

endpackage

// File: rtl/spi_frame_rx.sv
// Frame deserialiser: counts rising edges, shifts in bits, tracks the status bit index.
// csb_i high clears all frame state asynchronously; frame_done is valid during the 24th rise.
module spi_frame_rx
  import spi_debug_pkg::*;
(
  input  logic              sclk_i,
  input  logic              resetb,
  input  logic              csb_i,
  input  logic              si_i,
  output logic              frame_done,
  output logic [CMD_W-1:0]  cmd,
  output logic [DATA_W-1:0] data,
  output logic              in_cmd_phase,
  output logic [2:0]        tx_idx
);

  localparam logic [4:0] CNT_LAST = 5'(FRAME_LEN - 1);
  localparam logic [4:0] CNT_FULL = 5'(FRAME_LEN);
  localparam logic [4:0] CNT_CMD  = 5'(CMD_W);

  logic [4:0]           rx_cnt;
  logic [FRAME_LEN-2:0] shift;

  // Saturates at a full frame so trailing clocks can never produce a second commit.
  always_ff @(posedge sclk_i or negedge resetb or posedge csb_i) begin
    if (!resetb) begin
      rx_cnt <= '0;
      shift  <= '0;
    end else if (csb_i) begin
      rx_cnt <= '0;
      shift  <= '0;
    end else if (rx_cnt != CNT_FULL) begin
      rx_cnt <= rx_cnt + 5'd1;
      shift  <= {shift[FRAME_LEN-3:0], si_i};
    end
  end

  always_ff @(negedge sclk_i or negedge resetb or posedge csb_i) begin
    if (!resetb) begin
      tx_idx <= '0;
    end else if (csb_i) begin
      tx_idx <= '0;
    end else if (in_cmd_phase) begin
      tx_idx <= tx_idx + 3'd1;
    end
  end

  assign in_cmd_phase = (rx_cnt < CNT_CMD);
  assign frame_done   = (rx_cnt == CNT_LAST) && !csb_i;
  // The last bit is taken straight from si_i so the commit lands on the 24th edge itself.
  assign {cmd, data}  = {shift, si_i};

endmodule

// File: rtl/spi_debug_ctrl.sv
// SPI mode-3 debug control slave: decodes 24-bit frames into CPU halt/step/breakpoint/override controls.
// Commit on the 24th rising sclk_i edge; status byte shifts out on so_o during the command byte.
module spi_debug_ctrl
  import spi_debug_pkg::*;
(
  input  logic              sclk_i,
  input  logic              resetb,
  input  logic              csb_i,
  input  logic              si_i,
  output logic              so_o,
  output logic              halt_o,
  output logic              step_tgl_o,
  output logic [1:0]        wr_sel_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              wr_tgl_o,
  output logic [DATA_W-1:0] bp_addr_o,
  output logic              bp_en_o,
  output logic              err_o
);

  logic              frame_done;
  logic [CMD_W-1:0]  cmd;
  logic [DATA_W-1:0] data;
  logic              in_cmd_phase;
  logic [2:0]        tx_idx;
  logic [7:0]        stat;

  spi_frame_rx u_rx (
    .sclk_i       (sclk_i),
    .resetb       (resetb),
    .csb_i        (csb_i),
    .si_i         (si_i),
    .frame_done   (frame_done),
    .cmd          (cmd),
    .data         (data),
    .in_cmd_phase (in_cmd_phase),
    .tx_idx       (tx_idx)
  );

  always_ff @(posedge sclk_i or negedge resetb) begin
    if (!resetb) begin
      halt_o     <= 1'b0;
      step_tgl_o <= 1'b0;
      wr_sel_o   <= SEL_D;
      wr_data_o  <= '0;
      wr_tgl_o   <= 1'b0;
      bp_addr_o  <= '0;
      bp_en_o    <= 1'b0;
      err_o      <= 1'b0;
    end else if (frame_done) begin
      case (cmd)
        CMD_HALT:   halt_o <= 1'b1;
        CMD_RUN:    halt_o <= 1'b0;
        // A step while running is silently dropped, not flagged as an error.
        CMD_STEP:   if (halt_o) step_tgl_o <= ~step_tgl_o;
        CMD_WR_D, CMD_WR_A, CMD_WR_PC: begin
          wr_sel_o  <= (cmd == CMD_WR_D) ? SEL_D : (cmd == CMD_WR_A) ? SEL_A : SEL_PC;
          wr_data_o <= data;
          wr_tgl_o  <= ~wr_tgl_o;
        end
        CMD_BPADDR: bp_addr_o <= data;
        CMD_BPEN:   bp_en_o   <= data[0];
        CMD_CLRERR: err_o     <= 1'b0;
        default:    err_o     <= 1'b1;
      endcase
    end
  end

  assign stat = {err_o, halt_o, bp_en_o, step_tgl_o, wr_tgl_o, 3'b000};
  assign so_o = (in_cmd_phase && !csb_i) ? stat[3'd7 - tx_idx] : 1'b0;

endmodule
